mario_jump_ctrl: RTL
====================

# mario_jump_ctrl

Sequences Mario's vertical jump arc from a request pulse: timing via an internal tick divider, state via a rise/apex/fall state machine, and a registered screen Y coordinate for the draw datapath. It sits between the controller input logic and the Mario sprite position register. It replaces free-running jump enables with a divider that runs only while a jump is in progress, so every jump has a deterministic cycle count.

## Interface
- TICK_DIV, 10000: clock cycles per vertical step (≥2)
- JUMP_HEIGHT, 40: pixels risen per jump (≥1)
- HOLD_TICKS, 4: ticks spent at apex (0 = no apex dwell)
- GROUND_Y, 100: screen Y of standing Mario (up = smaller Y; requires GROUND_Y ≥ 2·JUMP_HEIGHT)
- Y_W, 7: width of Y coordinate
- clock  in  1  system clock, all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- jump  in  1  jump request, sampled each posedge, level-sensitive
- y  out  Y_W  Mario screen Y, registered
- airborne  out  1  high in any state other than IDLE
- land  out  1  one-cycle pulse on return to ground

## Operation
- Internal registers: state, height h (Y_W bits, height above ground), target t, divider counter (27 bits), hold counter.
- Output mapping: y = GROUND_Y − h, registered.
- Divider: loaded with TICK_DIV−1 on entry to RISE from a jump; decrements each cycle when not IDLE; at 0 it asserts an internal tick for one cycle and reloads to TICK_DIV−1. It is held at TICK_DIV−1 in IDLE.
- States:
  - IDLE: h=0. If jump=1, set t=JUMP_HEIGHT and go to RISE.
  - RISE: on tick, h←h+1. If the new h equals t, go to APEX (or to FALL if HOLD_TICKS=0). The hold counter loads HOLD_TICKS.
  - APEX: on tick, decrement the hold counter. When it reaches 0, go to FALL on that edge.
  - FALL: on tick, h←h−1. If the new h equals 0, go to IDLE and assert land for the next cycle.
- jump is ignored in RISE and APEX.
- jump is ignored in FALL unless JUMP_DOUBLE_EN is compiled in (see Configuration).
- Holding jump high in IDLE after landing starts a new jump on the edge after land, with no gap.

## Timing
- Reset values: state=IDLE, h=0, y=GROUND_Y, airborne=0, land=0, divider=TICK_DIV−1, hold counter=0.
- The jump sampled high at edge N puts state=RISE and airborne=1 visible after edge N.
- The first tick occurs TICK_DIV cycles after edge N, so y first changes after edge N+TICK_DIV.
- Ticks occur every TICK_DIV cycles thereafter; exactly one h step per tick.
- Full single jump duration is (2·JUMP_HEIGHT + HOLD_TICKS)·TICK_DIV cycles from edge N to the IDLE edge.
- At the IDLE edge: airborne drops and land rises; land lasts exactly 1 cycle.
- Jump and tick in the same cycle in FALL (double enabled): the jump wins, no h step occurs that cycle, and the divider reloads.
- Reset asserted mid-jump: all registers return to reset values immediately (asynchronous). No land pulse is produced.

## Configuration
- JUMP_DOUBLE_EN defined:
  - A jump sampled high in FALL, when the double-used flag is clear, sets t=h+JUMP_HEIGHT, sets the double-used flag, reloads the divider, and goes to RISE.
  - The double-used flag clears in IDLE.
  - A jump in APEX or RISE is still ignored.
- JUMP_DOUBLE_EN undefined: the flag logic is absent, and jump is ignored in every state except IDLE.

## Test plan
- Params TICK_DIV=4, JUMP_HEIGHT=3, HOLD_TICKS=2, GROUND_Y=10; jump pulse at edge 0:
  - y goes 9, 8, 7 at edges 4, 8, 12, holds 7 through edge 20, then goes 8, 9, 10 at edges 24, 28, 32.
  - land is high only in the cycle after edge 32; airborne is high from edge 0 to edge 32.
- Same params, HOLD_TICKS=0: y is 7 at edge 12, 8 at edge 16, and 10 at edge 24; land follows edge 24.
- resetn low at cycle 10 mid-rise: y=10, airborne=0, land=0 immediately. A jump after release restarts a full arc, with the first step 4 cycles later.
- jump held high continuously: back-to-back arcs, each new RISE starting on the edge after land. Jump pulses during RISE and APEX have no effect (with the macro undefined, also in FALL).
- JUMP_DOUBLE_EN defined; jump at edge 0, second jump at edge 25 (FALL, h=2) coinciding with no tick:
  - t=5, and y reaches 5 at edge 37.
  - A third jump during the following FALL is ignored.
  - land occurs after edge 65.

Source files
------------

// File: rtl/mario_jump_ctrl.sv
// mario_jump_ctrl
// ---------------------------------------------------------------------------
// Sequences Mario's vertical jump arc from a level-sensitive jump request.
// A tick divider runs only while a jump is in progress, so every arc has a
// deterministic cycle count. A rise/apex/fall state machine steps the height
// above ground once per tick, and the screen Y (up = smaller Y) is
// registered for the sprite draw datapath.
//
// Optional feature: define JUMP_DOUBLE_EN to allow one extra jump during
// FALL. The flag that limits this to one extra jump clears back in IDLE.
//
// Ports
//   clock    in            system clock, all logic on posedge
//   resetn   in            asynchronous active-low reset
//   jump     in            jump request, sampled each posedge
//   y        out [Y_W-1:0] registered screen Y = GROUND_Y - height
//   airborne out           high in every state other than IDLE
//   land     out           one-cycle pulse after returning to ground
// ---------------------------------------------------------------------------
module mario_jump_ctrl #(
    parameter int TICK_DIV    = 10000, // clock cycles per vertical step (>= 2)
    parameter int JUMP_HEIGHT = 40,    // pixels risen per jump (>= 1)
    parameter int HOLD_TICKS  = 4,     // ticks spent at apex (0 = no dwell)
    parameter int GROUND_Y    = 100,   // screen Y of standing Mario
    parameter int Y_W         = 7      // width of the Y coordinate
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           jump,
    output logic [Y_W-1:0] y,
    output logic           airborne,
    output logic           land
);

    localparam int DIV_W  = 27;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLD_TICKS);
    localparam logic [Y_W-1:0]    JUMP_H     = Y_W'(JUMP_HEIGHT);
    localparam logic [Y_W-1:0]    GROUND     = Y_W'(GROUND_Y);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RISE,
        S_APEX,
        S_FALL
    } state_t;

    state_t            state, state_n;
    logic [Y_W-1:0]    h, h_n;          // height above ground
    logic [Y_W-1:0]    t, t_n;          // height at which the rise stops
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic              land_n;
    logic              tick;
    logic              double_go;       // accept an extra jump this cycle

`ifdef JUMP_DOUBLE_EN
    logic dbl_used, dbl_n;
    assign double_go = jump && !dbl_used;
`else
    assign double_go = 1'b0;
`endif

    // The divider only counts outside IDLE, so a tick can never fire while
    // standing; it is the single event that advances the arc.
    assign tick     = (state != S_IDLE) && (div_cnt == '0);
    assign airborne = (state != S_IDLE);

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n = state;
        h_n     = h;
        t_n     = t;
        hold_n  = hold_cnt;
        land_n  = 1'b0;
`ifdef JUMP_DOUBLE_EN
        dbl_n   = dbl_used;
`endif
        if (state == S_IDLE || tick) begin
            div_n = DIV_RELOAD;
        end else begin
            div_n = div_cnt - DIV_W'(1);
        end

        case (state)
            S_IDLE: begin
                h_n = '0;
`ifdef JUMP_DOUBLE_EN
                dbl_n = 1'b0;
`endif
                if (jump) begin
                    t_n     = JUMP_H;
                    div_n   = DIV_RELOAD;
                    state_n = S_RISE;
                end
            end
            S_RISE: begin
                if (tick) begin
                    h_n = h + Y_W'(1);
                    if ((h + Y_W'(1)) == t) begin
                        hold_n  = HOLD_INIT;
                        state_n = (HOLD_TICKS == 0) ? S_FALL : S_APEX;
                    end
                end
            end
            S_APEX: begin
                if (tick) begin
                    hold_n = hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) begin
                        state_n = S_FALL;
                    end
                end
            end
            S_FALL: begin
                // An accepted extra jump beats a coincident tick: no height
                // step that cycle, and the divider restarts a full period.
                if (double_go) begin
                    t_n     = h + JUMP_H;
                    div_n   = DIV_RELOAD;
                    state_n = S_RISE;
`ifdef JUMP_DOUBLE_EN
                    dbl_n   = 1'b1;
`endif
                end else if (tick) begin
                    h_n = h - Y_W'(1);
                    if (h == Y_W'(1)) begin
                        state_n = S_IDLE;
                        land_n  = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized
    // flops regardless of block ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            h        <= '0;
            t        <= '0;
            div_cnt  <= DIV_RELOAD;
            hold_cnt <= '0;
            land     <= 1'b0;
            y        <= GROUND;
`ifdef JUMP_DOUBLE_EN
            dbl_used <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            h        <= h_n;
            t        <= t_n;
            div_cnt  <= div_n;
            hold_cnt <= hold_n;
            land     <= land_n;
            // Y is registered from the next height so it moves on the same
            // edge as the height itself.
            y        <= GROUND - h_n;
`ifdef JUMP_DOUBLE_EN
            dbl_used <= dbl_n;
`endif
        end
    end

endmodule
